decoder3to8_design: RTL and testbench

//   Registered 3-to-8 line decoder: drives exactly one of eight output lines from a 3-bit code.

---
 rtl/decoder3to8_design.sv | 102 ++++++++++
 tb/tb_decoder3to8_design.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/decoder3to8_design.sv
// Registered 3-to-8 line decoder with elaboration-time polarity and optional combinational bypass.
// Optional statistics outputs (hit_cnt, last_i, onehot_err) are enabled by defining DEC3TO8_STATS_EN.
module decoder3to8_design #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REG_OUT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  i,
    output logic [7:0]  y,
    output logic        valid
`ifdef DEC3TO8_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [2:0]  last_i,
    output logic        onehot_err
`endif
);

    localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

    // True when more than one line is at the active level (idle is allowed).
    function automatic logic multi_hot(input logic [7:0] v);
        return ((v & (v - 8'h01)) != 8'h00);
    endfunction

    logic [7:0] dec_s;
    logic [7:0] y_next_s;
    logic [7:0] y_r;
    logic       valid_r;

    // Active-high decode; unknown codes fall into the default branch and stay idle.
    always_comb begin
        dec_s = 8'h00;
        if (en == 1'b1) begin
            case (i)
                3'd0:    dec_s = 8'h01;
                3'd1:    dec_s = 8'h02;
                3'd2:    dec_s = 8'h04;
                3'd3:    dec_s = 8'h08;
                3'd4:    dec_s = 8'h10;
                3'd5:    dec_s = 8'h20;
                3'd6:    dec_s = 8'h40;
                3'd7:    dec_s = 8'h80;
                default: dec_s = 8'h00;
            endcase
        end else begin
            dec_s = 8'h00;
        end
    end

    assign y_next_s = dec_s ^ INACTIVE;

    // Output line register and valid flag; reset discards any pending decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r     <= INACTIVE;
            valid_r <= 1'b0;
        end else begin
            y_r     <= y_next_s;
            valid_r <= en;
        end
    end

    // The bypass leaves y_r in place so the encoding checker always sees the registered decode.
    assign y     = REG_OUT ? y_r : y_next_s;
    assign valid = valid_r;

`ifdef DEC3TO8_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [2:0]  last_i_r;
    logic        onehot_err_r;

    // Enabled-edge counter (saturating), last code capture and encoding error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r    <= 16'h0000;
            last_i_r     <= 3'b000;
            onehot_err_r <= 1'b0;
        end else begin
            if (en) begin
                if (hit_cnt_r != 16'hFFFF) begin
                    hit_cnt_r <= hit_cnt_r + 16'h0001;
                end else begin
                    hit_cnt_r <= hit_cnt_r;
                end
                last_i_r <= i;
            end else begin
                hit_cnt_r <= hit_cnt_r;
                last_i_r  <= last_i_r;
            end
            onehot_err_r <= valid_r & multi_hot(y_r ^ INACTIVE);
        end
    end

    assign hit_cnt    = hit_cnt_r;
    assign last_i     = last_i_r;
    assign onehot_err = onehot_err_r;
`endif

endmodule

// File: tb/tb_decoder3to8_design.sv
// Self-checking bench for decoder3to8_design: directed steps plus random traffic against a shift-based model.
// Exercises default, ACTIVE_LOW=1 and REG_OUT=0 instances driven from the same inputs.
module tb_decoder3to8_design;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [2:0] i   = 3'b101;

    logic [7:0] y_hi, y_lo, y_cb;
    logic       v_hi, v_lo, v_cb;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [7:0]  exp_y;
    logic        exp_v;
`ifdef DEC3TO8_STATS_EN
    logic [15:0] hc_hi, hc_lo, hc_cb, exp_hc;
    logic [2:0]  li_hi, li_lo, li_cb, exp_li;
    logic        oe_hi, oe_lo, oe_cb;
`endif

    always #5 clk = ~clk;

    decoder3to8_design #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .i(i), .y(y_hi), .valid(v_hi)
`ifdef DEC3TO8_STATS_EN
        , .hit_cnt(hc_hi), .last_i(li_hi), .onehot_err(oe_hi)
`endif
    );

    decoder3to8_design #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .i(i), .y(y_lo), .valid(v_lo)
`ifdef DEC3TO8_STATS_EN
        , .hit_cnt(hc_lo), .last_i(li_lo), .onehot_err(oe_lo)
`endif
    );

    decoder3to8_design #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) dut_cb (
        .clk(clk), .rst(rst), .en(en), .i(i), .y(y_cb), .valid(v_cb)
`ifdef DEC3TO8_STATS_EN
        , .hit_cnt(hc_cb), .last_i(li_cb), .onehot_err(oe_cb)
`endif
    );

    // Reference decode: a single shifted bit when enabled with a known code, else idle.
    function automatic logic [7:0] model_dec(input logic e, input logic [2:0] c);
        if (e !== 1'b1 || $isunknown(c)) return 8'h00;
        return 8'h01 << c;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check bypass output, advance model on the edge, check registered outputs.
    task automatic step(input logic r, input logic e, input logic [2:0] c);
        @(negedge clk);
        rst = r;
        en  = e;
        i   = c;
        #1;
        chk("comb_y", {8'h00, y_cb}, {8'h00, model_dec(e, c)});
        @(posedge clk);
        if (r) begin
            exp_y = 8'h00;
            exp_v = 1'b0;
`ifdef DEC3TO8_STATS_EN
            exp_hc = 16'h0000;
            exp_li = 3'b000;
`endif
        end else begin
            exp_y = model_dec(e, c);
            exp_v = e;
`ifdef DEC3TO8_STATS_EN
            if (e) begin
                exp_hc = (exp_hc == 16'hFFFF) ? exp_hc : exp_hc + 16'd1;
                exp_li = c;
            end
`endif
        end
        #1;
        chk("y",        {8'h00, y_hi}, {8'h00, exp_y});
        chk("valid",    {15'h0, v_hi}, {15'h0, exp_v});
        chk("y_al",     {8'h00, y_lo}, {8'h00, ~exp_y});
        chk("valid_al", {15'h0, v_lo}, {15'h0, exp_v});
        chk("valid_cb", {15'h0, v_cb}, {15'h0, exp_v});
`ifdef DEC3TO8_STATS_EN
        chk("hit_cnt",    hc_hi, exp_hc);
        chk("last_i",     {13'h0, li_hi}, {13'h0, exp_li});
        chk("onehot_err", {15'h0, oe_hi | oe_lo | oe_cb}, 16'h0000);
`endif
    endtask

    initial begin
        logic [7:0] fixed_y;
        exp_y = 8'h00;
        exp_v = 1'b0;
`ifdef DEC3TO8_STATS_EN
        exp_hc = 16'h0000;
        exp_li = 3'b000;
`endif
        // Reset held two cycles with an active request, then released.
        step(1'b1, 1'b1, 3'b101);
        step(1'b1, 1'b1, 3'b101);
        chk("rst_y", {8'h00, y_hi}, 16'h0000);
        step(1'b0, 1'b1, 3'b101);
        chk("first_y", {8'h00, y_hi}, 16'h0020);

        // Sweep with fixed expectations.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, k[2:0]);
            fixed_y = 8'h01 << k;
            chk("sweep_y", {8'h00, y_hi}, {8'h00, fixed_y});
            chk("sweep_v", {15'h0, v_hi}, 16'h0001);
        end

        // Enable gating.
        step(1'b0, 1'b0, 3'b011);
        chk("gate_off_y", {8'h00, y_hi}, 16'h0000);
        chk("gate_off_al", {8'h00, y_lo}, 16'h00FF);
        step(1'b0, 1'b1, 3'b011);
        chk("gate_on_y", {8'h00, y_hi}, 16'h0008);
        step(1'b0, 1'b1, 3'b010);
        chk("al_fb", {8'h00, y_lo}, 16'h00FB);

        // Mid-stream reset at code 4, then resume.
        for (int k = 0; k < 8; k++) begin
            step((k == 4) ? 1'b1 : 1'b0, 1'b1, k[2:0]);
        end
        step(1'b0, 1'b1, 3'b111);
        chk("wrap_y", {8'h00, y_hi}, 16'h0080);

        // Unknown code while enabled.
        step(1'b0, 1'b1, 3'bxxx);

`ifdef DEC3TO8_STATS_EN
        // Ten enabled cycles straight after reset, then reset again.
        step(1'b1, 1'b0, 3'b000);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 3'(k));
        chk("hit10", hc_hi, 16'd10);
        step(1'b1, 1'b1, 3'b001);
        chk("hit0", hc_hi, 16'd0);
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
